pipeline_2_execute_reg: RTL

//  Read-register -> execute pipeline register. Accepts the decoded fields

---
 rtl/pipeline_2_execute_reg.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_2_execute_reg.sv
// rtl/pipeline_2_execute_reg.sv - read-register to execute pipeline register with forwarding and load-use stall
//
// Purpose:
//   Captures the decoded instruction fields and register-file read data
//   for the execute stage. The writeback result is forwarded into the
//   operands. A load-use hazard is handled by inserting LOAD_LAT bubbles
//   while upstream is held.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   update                global advance, 0 freezes all state
//   flush                 squash the instruction entering this stage
//   control_in ..         decoded fields from the read-register stage
//   rdata_m, rdata_n      register-file read data for Rm / Rn
//   wb_we, wb_num,
//   wb_value              writeback port used for forwarding
//   control_out ..        registered fields for the execute stage
//   opA_out, opB_out      registered (forwarded) operands
//   stall_up              combinational, 1 = upstream must hold

module pipeline_2_execute_reg #(
  parameter int LOAD_LAT = 1,
  parameter int W        = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         update,
  input  logic         flush,
  input  logic [21:0]  control_in,
  input  logic [2:0]   num_Rm_in,
  input  logic [2:0]   num_Rn_in,
  input  logic [2:0]   num_Rd_in,
  input  logic [2:0]   used_RmRnRd_in,
  input  logic [5:0]   inst_type_in,
  input  logic [W-1:0] imm_in,
  input  logic [W-1:0] delayed_B_in,
  input  logic [2:0]   delayed_cond_in,
  input  logic [W-1:0] rdata_m,
  input  logic [W-1:0] rdata_n,
  input  logic         wb_we,
  input  logic [2:0]   wb_num,
  input  logic [W-1:0] wb_value,
  output logic [21:0]  control_out,
  output logic [2:0]   num_Rd_out,
  output logic         used_Rd_out,
  output logic [5:0]   inst_type_out,
  output logic [W-1:0] opA_out,
  output logic [W-1:0] opB_out,
  output logic [W-1:0] imm_out,
  output logic [W-1:0] delayed_B_out,
  output logic [2:0]   delayed_cond_out,
  output logic         stall_up
);

  localparam logic [2:0] CNT_INIT = 3'(LOAD_LAT - 1);
  localparam int         LOAD_BIT = 8;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_t;

  state_t     state;
  logic [2:0] cnt;

  logic [W-1:0] opA_next;
  logic [W-1:0] opB_next;
  logic         haz;
  logic         capture;

  // Writeback forwarding: the register file is read before writeback lands,
  // so a same-cycle write to a used source register must bypass the read.
  always_comb begin
    opA_next = rdata_m;
    opB_next = rdata_n;
    if (wb_we && (wb_num == num_Rm_in) && used_RmRnRd_in[2]) opA_next = wb_value;
    if (wb_we && (wb_num == num_Rn_in) && used_RmRnRd_in[1]) opB_next = wb_value;
  end

  // A load sitting in this stage whose destination is read by the incoming
  // instruction. Bubbles carry control 0, so chained loads never re-trigger.
  always_comb begin
    haz = control_out[LOAD_BIT] && used_Rd_out &&
          ((used_RmRnRd_in[2] && (num_Rm_in == num_Rd_out)) ||
           (used_RmRnRd_in[1] && (num_Rn_in == num_Rd_out)));
  end

  always_comb begin
    capture  = (state == ST_RUN) && !haz && !flush;
    stall_up = update && !flush && (((state == ST_RUN) && haz) || (state == ST_BUBBLE));
  end

  // Datapath registers: real instruction on capture, all-zero bubble otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      control_out      <= '0;
      num_Rd_out       <= '0;
      used_Rd_out      <= 1'b0;
      inst_type_out    <= '0;
      opA_out          <= '0;
      opB_out          <= '0;
      imm_out          <= '0;
      delayed_B_out    <= '0;
      delayed_cond_out <= '0;
    end else if (update) begin
      if (capture) begin
        control_out      <= control_in;
        num_Rd_out       <= num_Rd_in;
        used_Rd_out      <= used_RmRnRd_in[0];
        inst_type_out    <= inst_type_in;
        opA_out          <= opA_next;
        opB_out          <= opB_next;
        imm_out          <= imm_in;
        delayed_B_out    <= delayed_B_in;
        delayed_cond_out <= delayed_cond_in;
      end else begin
        control_out      <= '0;
        num_Rd_out       <= '0;
        used_Rd_out      <= 1'b0;
        inst_type_out    <= '0;
        opA_out          <= '0;
        opB_out          <= '0;
        imm_out          <= '0;
        delayed_B_out    <= '0;
        delayed_cond_out <= '0;
      end
    end
  end

  // Bubble sequencer. The hazard cycle itself produces the first bubble,
  // so BUBBLE covers the remaining LOAD_LAT-1 and exits as cnt reaches 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else if (update) begin
      if (flush) begin
        state <= ST_RUN;
        cnt   <= '0;
      end else begin
        case (state)
          ST_RUN: begin
            if (haz) begin
              cnt   <= CNT_INIT;
              state <= (LOAD_LAT > 1) ? ST_BUBBLE : ST_RUN;
            end
          end
          ST_BUBBLE: begin
            if (cnt != 3'd0) cnt <= cnt - 3'd1;
            if (cnt <= 3'd1) state <= ST_RUN;
          end
          default: begin
            state <= ST_RUN;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
